// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM states and ALU operations for the
// multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  // Register-file write-back destination/source selection
  typedef enum logic [1:0] {
    WB_RD_ALU, WB_RT_ALU, WB_RT_MDR
  } wb_sel_t;

endpackage

// File: rtl/mips_mc_core_if.sv
// Unified memory port of the multicycle MIPS core.
interface mips_mc_core_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: decodes opcode/funct and sequences the datapath.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic    mem_ready,
  input  logic    a_eq_b,
  input  logic    addr_misaligned,
  output logic    mem_req,
  output logic    mem_we,
  output logic    addr_from_alu,
  output logic    ir_load,
  output logic    ab_load,
  output logic    alu_load,
  output logic    alu_src_imm,
  output logic    pc_from_alu,
  output logic    pc_jump,
  output logic    mdr_load,
  output logic    rf_we,
  output alu_op_t alu_op,
  output wb_sel_t wb_sel,
  output logic    retire,
  output logic    trap
);

  state_t  state, state_nx;
  logic    legal;
  alu_op_t r_op;

  // Instruction legality and R-type ALU operation decode
  always_comb begin
    legal = 1'b1;
    r_op  = ALU_ADD;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: if (opcode == OP_RTYPE) legal = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ;
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state and control outputs
  always_comb begin
    state_nx      = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_from_alu = 1'b0;
    ir_load       = 1'b0;
    ab_load       = 1'b0;
    alu_load      = 1'b0;
    alu_src_imm   = 1'b0;
    pc_from_alu   = 1'b0;
    pc_jump       = 1'b0;
    mdr_load      = 1'b0;
    rf_we         = 1'b0;
    alu_op        = ALU_ADD;
    wb_sel        = WB_RD_ALU;
    retire        = 1'b0;
    trap          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_load  = 1'b1;
        state_nx = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_load = 1'b1;
            alu_op   = r_op;
            state_nx = S_WB;
          end
          OP_ADDI: begin
            alu_load    = 1'b1;
            alu_src_imm = 1'b1;
            state_nx    = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_load    = 1'b1;
            alu_src_imm = 1'b1;
            state_nx    = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            pc_from_alu = (opcode == OP_BEQ) ? a_eq_b : !a_eq_b;
            retire      = 1'b1;
            state_nx    = S_FETCH;
          end
          OP_J: begin
            pc_jump  = 1'b1;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
          default: state_nx = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (addr_misaligned) begin
          state_nx = S_TRAP;
        end else begin
          mem_req       = 1'b1;
          mem_we        = (opcode == OP_SW);
          addr_from_alu = 1'b1;
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              retire   = 1'b1;
              state_nx = S_FETCH;
            end else begin
              mdr_load = 1'b1;
              state_nx = S_WB;
            end
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = (opcode == OP_RTYPE) ? WB_RD_ALU :
                   (opcode == OP_ADDI)  ? WB_RT_ALU : WB_RT_MDR;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_nx = S_TRAP;
    endcase
  end

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS32 core datapath with register file and unified memory port.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_mc_core_if.master        mem,
  output logic [31:0]           pc_out,
  output logic                  retire,
  output logic                  trap
);

  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic [31:0] sext_imm, alu_b, alu_res, rs_val, rt_val, wr_data, addr_full;
  logic [4:0]  wr_idx;
  logic        mem_req_c, mem_we_c, addr_from_alu, ir_load, ab_load, alu_load;
  logic        alu_src_imm, pc_from_alu, pc_jump, mdr_load, rf_we;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  mips_mc_ctrl u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .opcode          (ir[31:26]),
    .funct           (ir[5:0]),
    .mem_ready       (mem.mem_ready),
    .a_eq_b          (a == b),
    .addr_misaligned (alu_out[1:0] != 2'b00),
    .mem_req         (mem_req_c),
    .mem_we          (mem_we_c),
    .addr_from_alu   (addr_from_alu),
    .ir_load         (ir_load),
    .ab_load         (ab_load),
    .alu_load        (alu_load),
    .alu_src_imm     (alu_src_imm),
    .pc_from_alu     (pc_from_alu),
    .pc_jump         (pc_jump),
    .mdr_load        (mdr_load),
    .rf_we           (rf_we),
    .alu_op          (alu_op),
    .wb_sel          (wb_sel),
    .retire          (retire),
    .trap            (trap)
  );

  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
  assign rt_val   = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
  assign addr_full = addr_from_alu ? alu_out : pc;

  // Request is gated by rst so an in-flight transfer drops immediately on reset
  assign mem.mem_req   = mem_req_c & ~rst;
  assign mem.mem_we    = mem_we_c & ~rst;
  assign mem.mem_addr  = addr_full[ADDR_W-1:0];
  assign mem.mem_wdata = b;
  assign pc_out        = pc;

  // ALU
  always_comb begin
    alu_b = alu_src_imm ? sext_imm : b;
    case (alu_op)
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(a) < $signed(alu_b)};
      default: alu_res = a + alu_b;
    endcase
  end

  // Register-file write port selection
  always_comb begin
    wr_idx  = ir[15:11];
    wr_data = alu_out;
    case (wb_sel)
      WB_RT_ALU: wr_idx = ir[20:16];
      WB_RT_MDR: begin
        wr_idx  = ir[20:16];
        wr_data = mdr;
      end
      default: ;
    endcase
  end

  // Architectural and internal datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (ir_load) begin
        ir <= mem.mem_rdata;
        pc <= pc + 32'd4;
      end
      if (ab_load) begin
        a       <= rs_val;
        b       <= rt_val;
        alu_out <= pc + {sext_imm[29:0], 2'b00};
      end
      if (alu_load)    alu_out <= alu_res;
      if (mdr_load)    mdr     <= mem.mem_rdata;
      if (pc_from_alu) pc      <= alu_out;
      if (pc_jump)     pc      <= {pc[31:28], ir[25:0], 2'b00};
    end
  end

  // Register file; r0 writes are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && wr_idx != 5'd0) begin
      rf[wr_idx] <= wr_data;
    end
  end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 Parameter ADDR_W, default 32: width of mem_addr; the low ADDR_W bits of the byte address are driven.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  in  1  reset, asynchronous and active-high.
REQ-005 mem_req  out  1  memory transfer request.
REQ-006 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-007 mem_addr  out  ADDR_W  byte address, word-aligned.
REQ-008 mem_wdata  out  32  store data; valid while mem_req & mem_we.
REQ-009 mem_rdata  in  32  read data; sampled in the completing cycle.
REQ-010 mem_ready  in  1  transfer completes in any cycle where mem_req & mem_ready.
REQ-011 pc_out  out  32  current PC.
REQ-012 retire  out  1  one-cycle pulse per completed instruction.
REQ-013 trap  out  1  sticky: an illegal instruction or misaligned access occurred.

Function
REQ-014 The block SHALL be a multicycle MIPS32 core with a unified memory port and FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 Supported opcodes:
- R-type 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
- 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j
REQ-016 Any other opcode or funct SHALL enter TRAP from DECODE.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on completion IR<=mem_rdata, PC<=PC+4, next DECODE; without completion, stay in FETCH.
REQ-018 DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2); next EXEC.
REQ-019 EXEC, R-type: ALUOut<=A op B, next WB.
REQ-020 EXEC, addi/lw/sw: ALUOut<=A+sext(imm); addi goes to WB, lw/sw go to MEM.
REQ-021 EXEC, beq (A==B) or bne (A!=B) taken: PC<=ALUOut; retire; next FETCH.
REQ-022 EXEC, j: PC<={PC[31:28],IR[25:0],2'b00}; retire; next FETCH.
REQ-023 MEM with ALUOut[1:0]!=0 SHALL go to TRAP without asserting mem_req.
REQ-024 MEM, lw: read at ALUOut; on completion MDR<=mem_rdata, next WB.
REQ-025 MEM, sw: mem_we=1, mem_wdata=B; on completion retire, next FETCH.
REQ-026 WB: rf[rd]<=ALUOut for R-type, rf[rt]<=ALUOut for addi, rf[rt]<=MDR for lw; retire; next FETCH.
REQ-027 Writes to r0 SHALL be discarded; reads of r0 SHALL return 0.
REQ-028 Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable until completion; mem_ready with mem_req=0 SHALL be ignored; unbounded wait is allowed.
REQ-029 ALU arithmetic: add, sub and addi wrap modulo 2^32 with no overflow trap; slt compares signed; sext means 16-to-32 sign extension.
REQ-030 Zero-wait cycles per instruction: branch/j 3, R-type/addi/sw 4, lw 5; each memory wait cycle adds 1.
REQ-031 TRAP: trap=1, mem_req=0, no state change until Rst.

Reset
REQ-032 While Rst=1: PC=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, all 32 registers=0, mem_req=0, mem_we=0, retire=0, trap=0.
REQ-033 Rst mid-transfer SHALL drop mem_req immediately; the first request after release is a fetch at RESET_PC.

Structure
REQ-034 A shared package mips_pkg SHALL hold the opcode and funct constants, the FSM state enum and the ALU operation codes.
REQ-035 The FSM SHALL live in sub-module mips_mc_ctrl, which decodes the opcode and funct to select state and muxes.
REQ-036 The datapath, including the register file, SHALL stay in mips_mc_core.

Verification
REQ-037 Load and add, zero wait: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, three retire pulses, total 12 cycles.
REQ-038 Load/store with waits, mem_ready delayed 3 cycles: sw r3,8(r0) then lw r4,8(r0) -> write of 12 at address 8 held stable; r4=12.
REQ-039 Branches: beq r1,r1,+2 -> PC=target; bne r1,r1,+2 -> PC=PC+4; j 0x40 -> PC=0x100.
REQ-040 Edge cases:
- slt r5,r6,r7 with r6=0xFFFFFFFF, r7=1 -> r5=1
- add 0x7FFFFFFF+1 -> 0x80000000, no trap
- addi r0,r0,9 -> r0 stays 0
REQ-041 Traps: opcode 0x3F -> trap=1, mem_req stays 0; lw at address 6 -> trap with no memory request.
REQ-042 Rst asserted during a wait-stated fetch -> mem_req=0 in the same cycle; after release, first mem_addr=RESET_PC.
